pair_stream_sync: RTL and testbench

Packet-pairing controller placed in front of two-input, lockstep stream blocks such as sum/difference units. It admits beats from two AXI-Stream inputs only as matched pairs and presents them on two outputs with a common valid, so downstream logic sees aligned packets. When packet lengths differ, it forces tlast on the shorter packet, flags an error and drains the rest of the longer input. It also keeps packet, error and dropped-beat counters for host readback.

---
 rtl/pair_stream_sync_pkg.sv | 14 +
 rtl/pair_out_reg.sv | 59 +++++
 rtl/pair_stream_sync.sv | 134 +++++++++++++
 tb/tb_pair_stream_sync.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_stream_sync_pkg.sv
// Shared definitions for the pair_stream_sync block.
//   state_e       : pairing FSM states (S_PAIR, S_DRAIN0, S_DRAIN1)
//   DEFAULT_CNT_W : default width of the status counters
package pair_stream_sync_pkg;

  localparam int unsigned DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    S_PAIR   = 2'd0,
    S_DRAIN0 = 2'd1,
    S_DRAIN1 = 2'd2
  } state_e;

endpackage

// File: rtl/pair_out_reg.sv
// Single-entry registered output stage shared by two lockstep AXI-Stream outputs.
// Ports:
//   clk, reset, clear        : clock, synchronous active-high reset and clear
//   load                     : load a new beat (only asserted by the caller when load_ok)
//   in0_data, in1_data       : beat payloads for outputs 0 and 1
//   in_last                  : tlast of the beat being loaded
//   out0_data, out1_data     : registered payloads
//   out_last, out_valid      : registered tlast and common valid
//   out0_ready, out1_ready   : downstream readies; the transfer needs both
//   load_ok                  : entry is empty or is being transferred this cycle
module pair_out_reg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] in0_data,
  input  logic [DW-1:0] in1_data,
  input  logic          in_last,
  output logic [DW-1:0] out0_data,
  output logic [DW-1:0] out1_data,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out0_ready,
  input  logic          out1_ready,
  output logic          load_ok
);

  logic [DW-1:0] data0_q, data1_q;
  logic          last_q, valid_q;
  logic          xfer;

  assign xfer    = valid_q & out0_ready & out1_ready;
  assign load_ok = ~valid_q | xfer;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data0_q <= '0;
      data1_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      data0_q <= in0_data;
      data1_q <= in1_data;
      last_q  <= in_last;
      valid_q <= 1'b1;
    end else if (xfer) begin
      // Payload is left in place; only valid drops once the beat has gone.
      valid_q <= 1'b0;
    end
  end

  assign out0_data = data0_q;
  assign out1_data = data1_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/pair_stream_sync.sv
// Packet-pairing controller for two AXI-Stream inputs feeding lockstep consumers.
// Beats are admitted only as matched pairs and presented with a common valid/tlast.
// On a length mismatch the shorter packet's tlast ends the output packet, err_stb
// pulses and the remainder of the longer packet is drained.
// Ports:
//   clk, reset, clear             : clock, synchronous active-high reset and clear
//   i0_* / i1_*                   : input streams (tdata, tlast, tvalid, tready)
//   o0_tdata, o1_tdata            : paired output payloads
//   o_tlast, o_tvalid             : common output tlast/valid
//   o0_tready, o1_tready          : downstream readies
//   err_stb                       : one-cycle pulse per length mismatch
//   pkt_cnt, err_cnt, drop_cnt    : wrapping status counters
module pair_stream_sync
  import pair_stream_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [2*WIDTH-1:0] i0_tdata,
  input  logic               i0_tlast,
  input  logic               i0_tvalid,
  output logic               i0_tready,
  input  logic [2*WIDTH-1:0] i1_tdata,
  input  logic               i1_tlast,
  input  logic               i1_tvalid,
  output logic               i1_tready,
  output logic [2*WIDTH-1:0] o0_tdata,
  output logic [2*WIDTH-1:0] o1_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o0_tready,
  input  logic               o1_tready,
  output logic               err_stb,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q, drop_cnt_q;
  logic             pkt_inc, drop_inc;
  logic             flush, load, load_ok, pair_ok;

  assign flush   = reset | clear;
  // Readies are held low during the reset/clear cycle so nothing is consumed.
  assign pair_ok = i0_tvalid & i1_tvalid & load_ok & ~flush;

  pair_out_reg #(
    .DW(2*WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .in0_data  (i0_tdata),
    .in1_data  (i1_tdata),
    .in_last   (i0_tlast | i1_tlast),
    .out0_data (o0_tdata),
    .out1_data (o1_tdata),
    .out_last  (o_tlast),
    .out_valid (o_tvalid),
    .out0_ready(o0_tready),
    .out1_ready(o1_tready),
    .load_ok   (load_ok)
  );

  always_comb begin
    state_d   = state_q;
    i0_tready = 1'b0;
    i1_tready = 1'b0;
    load      = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_PAIR: begin
        i0_tready = pair_ok;
        i1_tready = pair_ok;
        load      = pair_ok;
        if (pair_ok && (i0_tlast || i1_tlast)) begin
          pkt_inc = 1'b1;
          if (!i1_tlast) begin
            err_d   = 1'b1;
            state_d = S_DRAIN1;
          end else if (!i0_tlast) begin
            err_d   = 1'b1;
            state_d = S_DRAIN0;
          end
        end
      end
      S_DRAIN0: begin
        i0_tready = ~flush;
        if (i0_tvalid && !flush) begin
          drop_inc = 1'b1;
          if (i0_tlast) state_d = S_PAIR;
        end
      end
      S_DRAIN1: begin
        i1_tready = ~flush;
        if (i1_tvalid && !flush) begin
          drop_inc = 1'b1;
          if (i1_tlast) state_d = S_PAIR;
        end
      end
      default: state_d = S_PAIR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q    <= S_PAIR;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (pkt_inc)  pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
      if (err_d)    err_cnt_q  <= err_cnt_q + CNT_W'(1);
      if (drop_inc) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign err_stb  = err_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pair_stream_sync.sv
// Self-checking bench for pair_stream_sync: directed reset/clear/stall cases plus
// randomized packet streams compared against a packet-level reference model.
module tb_pair_stream_sync;

  localparam int unsigned W  = 16;
  localparam int unsigned DW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clear;
  logic [DW-1:0] i0_tdata, i1_tdata, o0_tdata, o1_tdata;
  logic          i0_tlast, i0_tvalid, i0_tready;
  logic          i1_tlast, i1_tvalid, i1_tready;
  logic          o_tlast, o_tvalid, o0_tready, o1_tready, err_stb;
  logic [15:0]   pkt_cnt, err_cnt, drop_cnt;

  pair_stream_sync #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
    .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
    .o0_tdata(o0_tdata), .o1_tdata(o1_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o0_tready(o0_tready), .o1_tready(o1_tready), .err_stb(err_stb),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  // Narrow-counter instance for the wrap case.
  logic          b_reset, b_i0_tvalid, b_i1_tvalid, b_i0_tready, b_i1_tready;
  logic [DW-1:0] b_o0_tdata, b_o1_tdata;
  logic          b_o_tlast, b_o_tvalid, b_err_stb;
  logic [3:0]    b_pkt_cnt, b_err_cnt, b_drop_cnt;

  pair_stream_sync #(.WIDTH(W), .CNT_W(4)) dut_w (
    .clk(clk), .reset(b_reset), .clear(1'b0),
    .i0_tdata(32'h0001_0001), .i0_tlast(1'b1), .i0_tvalid(b_i0_tvalid),
    .i0_tready(b_i0_tready),
    .i1_tdata(32'h0002_0002), .i1_tlast(1'b1), .i1_tvalid(b_i1_tvalid),
    .i1_tready(b_i1_tready),
    .o0_tdata(b_o0_tdata), .o1_tdata(b_o1_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid),
    .o0_tready(1'b1), .o1_tready(1'b1), .err_stb(b_err_stb),
    .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt), .drop_cnt(b_drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per round, one packet per input; output is the first min(len)
  // beat pairs with tlast on the last one; the surplus of the longer one is dropped.
  logic [DW:0]   s0_q[$], s1_q[$];   // {tlast, tdata}
  logic [2*DW:0] exp_q[$];           // {tlast, d0, d1}
  int exp_pkt, exp_err, exp_drop, seen_err;

  task automatic gen_rounds(input int n);
    int l0, l1, m, b0, b1;
    logic [DW:0] a, b;
    for (int r = 0; r < n; r++) begin
      l0 = $urandom_range(5, 1);
      l1 = ($urandom_range(1) == 0) ? l0 : $urandom_range(5, 1);
      m  = (l0 < l1) ? l0 : l1;
      b0 = s0_q.size();
      b1 = s1_q.size();
      for (int k = 0; k < l0; k++) s0_q.push_back({k == l0 - 1, DW'($urandom)});
      for (int k = 0; k < l1; k++) s1_q.push_back({k == l1 - 1, DW'($urandom)});
      for (int k = 0; k < m; k++) begin
        a = s0_q[b0 + k];
        b = s1_q[b1 + k];
        exp_q.push_back({k == m - 1, a[DW-1:0], b[DW-1:0]});
      end
      exp_pkt++;
      if (l0 != l1) begin
        exp_err++;
        exp_drop += (l0 > l1) ? (l0 - l1) : (l1 - l0);
      end
    end
  endtask

  logic done0, done1;

  task automatic drive0();
    logic fire;
    logic [DW:0] tmp;
    while (s0_q.size() > 0) begin
      if (!i0_tvalid && $urandom_range(3) != 0) begin
        tmp = s0_q[0];
        i0_tvalid = 1'b1;
        {i0_tlast, i0_tdata} = tmp;
      end
      @(negedge clk);
      fire = i0_tvalid & i0_tready;
      @(posedge clk);
      #1;
      if (fire) begin
        tmp = s0_q.pop_front();
        i0_tvalid = 1'b0;
      end
    end
    done0 = 1'b1;
  endtask

  task automatic drive1();
    logic fire;
    logic [DW:0] tmp;
    while (s1_q.size() > 0) begin
      if (!i1_tvalid && $urandom_range(3) != 0) begin
        tmp = s1_q[0];
        i1_tvalid = 1'b1;
        {i1_tlast, i1_tdata} = tmp;
      end
      @(negedge clk);
      fire = i1_tvalid & i1_tready;
      @(posedge clk);
      #1;
      if (fire) begin
        tmp = s1_q.pop_front();
        i1_tvalid = 1'b0;
      end
    end
    done1 = 1'b1;
  endtask

  // Downstream readies: random during random runs, otherwise both high.
  logic rdy_rand = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rdy_rand) begin
      o0_tready = ($urandom_range(3) != 0);
      o1_tready = ($urandom_range(3) != 0);
    end else begin
      o0_tready = 1'b1;
      o1_tready = 1'b1;
    end
  end

  // Output monitor: ordered comparison plus hold-stability while stalled.
  logic          mon_en = 1'b0;
  logic          stalled = 1'b0;
  logic [2*DW:0] held, cur;
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {o_tlast, o0_tdata, o1_tdata};
      if (err_stb) seen_err++;
      if (stalled) begin
        check("hold_valid", o_tvalid, 1'b1);
        check("hold_data", cur, held);
      end
      if (o_tvalid && o0_tready && o1_tready) begin
        if (exp_q.size() == 0) check("out_extra_beat", exp_q.size(), 1);
        else check("out_beat", cur, exp_q.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = o_tvalid;
      end
      held = cur;
    end
  end

  task automatic run_random(input int rounds);
    int cyc;
    exp_pkt = 0; exp_err = 0; exp_drop = 0; seen_err = 0;
    done0 = 1'b0; done1 = 1'b0; stalled = 1'b0;
    gen_rounds(rounds);
    mon_en = 1'b1;
    rdy_rand = 1'b1;
    fork
      drive0();
      drive1();
    join_none
    cyc = 0;
    while (cyc < 5000 && !(done0 && done1 && exp_q.size() == 0)) begin
      @(posedge clk);
      cyc++;
    end
    check("run_timeout", cyc < 5000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rdy_rand = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check("pkt_cnt", pkt_cnt, exp_pkt);
    check("err_cnt", err_cnt, exp_err);
    check("drop_cnt", drop_cnt, exp_drop);
    check("err_stb_pulses", seen_err, exp_err);
    check("idle_valid", o_tvalid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    reset = 1'b1; clear = 1'b0; b_reset = 1'b1;
    i0_tvalid = 1'b0; i0_tlast = 1'b0; i0_tdata = '0;
    i1_tvalid = 1'b0; i1_tlast = 1'b0; i1_tdata = '0;
    b_i0_tvalid = 1'b0; b_i1_tvalid = 1'b0;
    o0_tready = 1'b1; o1_tready = 1'b1;

    repeat (2) @(posedge clk);
    i0_tvalid = 1'b1; i1_tvalid = 1'b1;  // readies must still be 0 under reset
    @(negedge clk);
    check("rst_i0_tready", i0_tready, 1'b0);
    check("rst_i1_tready", i1_tready, 1'b0);
    check("rst_o_tvalid", o_tvalid, 1'b0);
    check("rst_counters", {pkt_cnt, err_cnt, drop_cnt, err_stb}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0; b_reset = 1'b0;

    // i1 withheld: nothing may be consumed from i0.
    i0_tdata = 32'h00AA_00AA;
    i1_tvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_i0_tready", i0_tready, 1'b0);
      check("hold_i1_tready", i1_tready, 1'b0);
      check("hold_no_out", o_tvalid, 1'b0);
      @(posedge clk);
      #1;
    end
    i0_tvalid = 1'b0;

    run_random(30);

    // Clear mid-packet in S_PAIR.
    i0_tvalid = 1'b1; i0_tlast = 1'b0; i0_tdata = 32'h0001_0001;
    i1_tvalid = 1'b1; i1_tlast = 1'b0; i1_tdata = 32'h0002_0002;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_clear_valid", o_tvalid, 1'b1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(negedge clk);
    check("clr_i0_tready", i0_tready, 1'b0);
    check("clr_i1_tready", i1_tready, 1'b0);
    @(posedge clk);
    #1;
    clear = 1'b0; i0_tvalid = 1'b0; i1_tvalid = 1'b0;
    @(negedge clk);
    check("clr_out", {o_tvalid, o_tlast, o0_tdata, o1_tdata}, '0);
    check("clr_counters", {pkt_cnt, err_cnt, drop_cnt}, '0);

    // Enter S_DRAIN0 (i1 ends first), then reset mid-drain.
    @(posedge clk);
    #1;
    i0_tvalid = 1'b1; i0_tlast = 1'b0; i0_tdata = 32'h0003_0003;
    i1_tvalid = 1'b1; i1_tlast = 1'b1; i1_tdata = 32'h0004_0004;
    @(posedge clk);
    #1;
    i1_tvalid = 1'b0;
    @(negedge clk);
    check("mm_err_stb", err_stb, 1'b1);
    check("mm_err_cnt", err_cnt, 16'd1);
    check("mm_pkt_cnt", pkt_cnt, 16'd1);
    check("mm_out", {o_tvalid, o_tlast, o0_tdata, o1_tdata},
          {1'b1, 1'b1, 32'h0003_0003, 32'h0004_0004});
    check("drain0_i0_tready", i0_tready, 1'b1);
    check("drain0_i1_tready", i1_tready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst2_i0_tready", i0_tready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0; i0_tvalid = 1'b0;
    @(negedge clk);
    check("rst2_counters", {pkt_cnt, err_cnt, drop_cnt, err_stb}, '0);
    check("rst2_o_tvalid", o_tvalid, 1'b0);
    @(posedge clk);
    #1;

    run_random(30);

    // Counter wrap with CNT_W=4: 17 one-beat pairs.
    b_i0_tvalid = 1'b1; b_i1_tvalid = 1'b1;
    hs = 0;
    for (int c = 0; c < 100 && hs < 17; c++) begin
      @(negedge clk);
      if (b_i0_tvalid && b_i0_tready && b_i1_tready) hs++;
      @(posedge clk);
      #1;
      if (hs == 17) begin
        b_i0_tvalid = 1'b0; b_i1_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    check("wrap_handshakes", hs, 17);
    check("wrap_pkt_cnt", b_pkt_cnt, 4'd1);
    check("wrap_err_cnt", b_err_cnt, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
